// File: rtl/ddr_pkg.sv
// Shared constants and state encoding for the DDR command arbiter.
package ddr_pkg;

   // Memory-port command instructions
   localparam logic [2:0] CMD_WR = 3'b000;
   localparam logic [2:0] CMD_RD = 3'b001;

   // Largest burst; burst-length fields carry (length - 1)
   localparam int unsigned BL_MAX = 64;
   localparam int unsigned BL_W   = $clog2(BL_MAX);

   typedef enum logic [1:0] {
      WAIT_CAL,
      IDLE,
      ISSUE,
      GAP
   } arb_state_e;

endpackage

// File: rtl/ddr_cmd_arbiter_if.sv
// Requester, memory command port and status signals of the DDR command arbiter.
interface ddr_cmd_arbiter_if #(
   parameter int unsigned ADDR_W = 30
);
   logic                     mem_calib_done;
   logic                     cmd_full;

   logic                     rq0_valid;
   logic [ddr_pkg::BL_W-1:0] rq0_bl;
   logic [ADDR_W-1:0]        rq0_addr;
   logic                     rq0_ack;

   logic                     rq1_valid;
   logic [ddr_pkg::BL_W-1:0] rq1_bl;
   logic [ADDR_W-1:0]        rq1_addr;
   logic                     rq1_ack;

   logic [2:0]               cmd_instr;
   logic [ddr_pkg::BL_W-1:0] cmd_bl;
   logic [ADDR_W-1:0]        cmd_byte_addr;
   logic                     cmd_en;
   logic                     addr_err;
   logic                     ready;

   // Requesters plus memory controller side
   modport master (
      output mem_calib_done, cmd_full,
      output rq0_valid, rq0_bl, rq0_addr,
      output rq1_valid, rq1_bl, rq1_addr,
      input  rq0_ack, rq1_ack,
      input  cmd_instr, cmd_bl, cmd_byte_addr, cmd_en, addr_err, ready
   );

   // Arbiter side
   modport slave (
      input  mem_calib_done, cmd_full,
      input  rq0_valid, rq0_bl, rq0_addr,
      input  rq1_valid, rq1_bl, rq1_addr,
      output rq0_ack, rq1_ack,
      output cmd_instr, cmd_bl, cmd_byte_addr, cmd_en, addr_err, ready
   );

endinterface

// File: rtl/ddr_cmd_arbiter_sync2.sv
// Two-flop synchroniser for the asynchronous calibration flag.
module sync2 (
   input  logic clk_i,
   input  logic reset_i,
   input  logic d_i,
   output logic q_o
);
   logic [1:0] sync_q;

   // Shift the raw input through two flops; reset clears both stages
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], d_i};
      end
   end

   assign q_o = sync_q[1];

endmodule

// File: rtl/ddr_cmd_arbiter.sv
// Two-requester command arbiter for a single memory command port:
// read priority with a bounded read streak while a write waits.
module ddr_cmd_arbiter
   import ddr_pkg::*;
#(
   parameter int unsigned MAX_STREAK = 4,
   parameter int unsigned ADDR_W     = 30
) (
   input  logic             clk,
   input  logic             reset,
   ddr_cmd_arbiter_if.slave bus
);
   localparam int unsigned         STREAK_W   = $clog2(MAX_STREAK + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

   arb_state_e          state_q, state_d;
   logic [STREAK_W-1:0] streak_q, streak_d;
   logic [2:0]          instr_q, instr_d;
   logic [BL_W-1:0]     bl_q, bl_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                cmd_en_q, cmd_en_d;
   logic                ack0_q, ack0_d;
   logic                ack1_q, ack1_d;
   logic                err_q, err_d;
   logic                ready_q, ready_d;

   logic                calib_sync;
   logic                grant_wr;
   logic [ADDR_W-1:0]   sel_addr;
   logic [BL_W-1:0]     sel_bl;

   sync2 u_cal_sync (
      .clk_i   (clk),
      .reset_i (reset),
      .d_i     (bus.mem_calib_done),
      .q_o     (calib_sync)
   );

   // Next-state, grant selection and command latch values
   always_comb begin
      state_d  = state_q;
      streak_d = streak_q;
      instr_d  = instr_q;
      bl_d     = bl_q;
      addr_d   = addr_q;
      ack0_d   = 1'b0;
      ack1_d   = 1'b0;
      err_d    = 1'b0;
      grant_wr = 1'b0;
      sel_addr = bus.rq0_addr;
      sel_bl   = bus.rq0_bl;

      case (state_q)
         WAIT_CAL: begin
            if (calib_sync) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            // After a misaligned reject the arbiter stays in IDLE while the
            // requester still sees its ack; skip that cycle so the same
            // request is not rejected twice.
            if (!bus.cmd_full && (bus.rq0_valid || bus.rq1_valid) && !ack0_q && !ack1_q) begin
               grant_wr = bus.rq1_valid && (!bus.rq0_valid || (streak_q == STREAK_MAX));
               sel_addr = grant_wr ? bus.rq1_addr : bus.rq0_addr;
               sel_bl   = grant_wr ? bus.rq1_bl : bus.rq0_bl;
               ack0_d   = !grant_wr;
               ack1_d   = grant_wr;
               if (sel_addr[1:0] != 2'b00) begin
                  err_d = 1'b1;
               end else begin
                  state_d = ISSUE;
                  instr_d = grant_wr ? CMD_WR : CMD_RD;
                  bl_d    = sel_bl;
                  addr_d  = sel_addr;
                  if (grant_wr || !bus.rq1_valid) begin
                     streak_d = '0;
                  end else if (streak_q != STREAK_MAX) begin
                     streak_d = streak_q + 1'b1;
                  end
               end
            end
         end
         ISSUE: begin
            state_d = GAP;
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = WAIT_CAL;
         end
      endcase

      cmd_en_d = (state_q == ISSUE);
      ready_d  = (state_d != WAIT_CAL);
   end

   // State, streak and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= WAIT_CAL;
         streak_q <= '0;
         instr_q  <= CMD_WR;
         bl_q     <= '0;
         addr_q   <= '0;
         cmd_en_q <= 1'b0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         err_q    <= 1'b0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         streak_q <= streak_d;
         instr_q  <= instr_d;
         bl_q     <= bl_d;
         addr_q   <= addr_d;
         cmd_en_q <= cmd_en_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         err_q    <= err_d;
         ready_q  <= ready_d;
      end
   end

   assign bus.cmd_instr     = instr_q;
   assign bus.cmd_bl        = bl_q;
   assign bus.cmd_byte_addr = addr_q;
   assign bus.cmd_en        = cmd_en_q;
   assign bus.rq0_ack       = ack0_q;
   assign bus.rq1_ack       = ack1_q;
   assign bus.addr_err      = err_q;
   assign bus.ready         = ready_q;

endmodule

// File: doc/ddr_cmd_arbiter.md
Name: ddr_cmd_arbiter

Overview:
- Shares the single memory-controller command port between two requesters: the display prefetch path (reads, requester 0) and the Mandelbrot pixel writer (writes, requester 1).
- Sits between the requesters and the cmd_* pins of the memory port.
- Gates all traffic on calibration and issues one command per grant.
- Uses fixed read priority with an anti-starvation streak limit, so the frame buffer fills while the HDMI stream stays fed.

Parameters:
- MAX_STREAK, 4, maximum consecutive read grants while a write is pending before the write is forced.
- ADDR_W, 30, command byte-address width.

Ports:
- clk  in  1  memory-side user clock.
- reset  in  1  synchronous, active-high; all state cleared on the clk edge where it is sampled high.
- mem_calib_done  in  1  controller calibration flag; asynchronous to clk, double-flopped internally.
- cmd_full  in  1  controller command FIFO full.
- rq0_valid  in  1  read request pending; held until rq0_ack.
- rq0_bl  in  6  burst length minus 1.
- rq0_addr  in  ADDR_W  byte address.
- rq0_ack  out  1  one-cycle pulse: request 0 accepted.
- rq1_valid  in  1  write request pending; held until rq1_ack.
- rq1_bl  in  6  burst length minus 1.
- rq1_addr  in  ADDR_W  byte address.
- rq1_ack  out  1  one-cycle pulse: request 1 accepted.
- cmd_instr  out  3  3'b001 read, 3'b000 write.
- cmd_bl  out  6  burst length minus 1.
- cmd_byte_addr  out  ADDR_W  byte address.
- cmd_en  out  1  command strobe, one cycle.
- addr_err  out  1  one-cycle pulse: misaligned request rejected.
- ready  out  1  calibration seen, arbiter accepting.

Behaviour:
- Reset values:
  - cmd_en, rq0_ack, rq1_ack, addr_err, ready = 0.
  - cmd_instr = 3'b000, cmd_bl = 0, cmd_byte_addr = 0.
  - streak = 0; state = WAIT_CAL; calibration synchroniser cleared.
- WAIT_CAL:
  - ready = 0.
  - Move to IDLE on the first cycle the synchronised calib bit is 1. That is 2 clk after mem_calib_done rises, plus one cycle for the state update.
  - ready = 1 from IDLE onward.
- IDLE grant rule: grant only when !cmd_full and at least one valid.
  - Only rq0 valid: grant 0.
  - Only rq1 valid: grant 1.
  - Both valid: grant 1 if streak == MAX_STREAK, otherwise grant 0.
- On grant (IDLE -> ISSUE, same edge):
  - Latch instr, bl and addr into the cmd_* registers.
  - Assert the granted rqN_ack for exactly one cycle.
  - Record which requester won.
- Misaligned request (addr[1:0] != 0):
  - No command is issued.
  - rqN_ack and addr_err pulse together.
  - State stays IDLE and streak is unchanged.
- ISSUE: cmd_en = 1 for exactly one cycle. Next state is GAP.
- GAP:
  - cmd_en = 0, then return to IDLE.
  - Minimum spacing between cmd_en pulses is 3 cycles.
  - Acknowledge-to-cmd_en latency is 1 cycle.
- Streak update at each issued command:
  - Read issued while rq1_valid: streak += 1, saturating at MAX_STREAK.
  - Read issued with rq1 idle: streak = 0.
  - Write issued: streak = 0.
- cmd_full rising during ISSUE is ignored; the command was granted under !cmd_full.
- rqN_valid dropping before ack is legal; that request is simply not granted.
- Requester inputs are sampled only in IDLE. Changes in ISSUE or GAP have no effect.
- reset asserted mid-ISSUE: cmd_en is 0 on the next cycle, state is WAIT_CAL, and the synchroniser restarts.
- mem_calib_done falling after IDLE is ignored until the next reset.

Decomposition:
- Shared package (ddr_pkg) holds:
  - Instruction constants: CMD_WR = 3'b000, CMD_RD = 3'b001.
  - The state encoding: WAIT_CAL, IDLE, ISSUE, GAP.
  - Default burst constant BL_MAX = 64.
- One natural sub-module, sync2: the 2-flop synchroniser for mem_calib_done.
- Arbitration and the FSM stay flat in this module.

Test Plan:
- Calibration gating: requests valid from t=0, mem_calib_done rises at cycle 10 -> ready = 1 and the first cmd_en at or after cycle 14; no cmd_en before that.
- Single read: rq0 with addr 0x100 and bl 63 -> rq0_ack, then cmd_en one cycle later with cmd_instr = 001, cmd_bl = 63, cmd_byte_addr = 0x100.
- Starvation limit (MAX_STREAK = 4): rq0 and rq1 continuously valid -> grant order R, R, R, R, W, R, R, R, R, W; cmd_en pulses spaced exactly 3 cycles apart.
- Backpressure: cmd_full held high for 20 cycles with both requests valid -> no ack and no cmd_en; first grant on the cycle after cmd_full falls, going to rq0.
- Misaligned write: rq1_addr = 0x102 -> rq1_ack and addr_err pulse together, no cmd_en, streak unchanged.
- Reset mid-operation: reset asserted on the ISSUE cycle -> cmd_en = 0 next cycle, ready = 0, full calibration wait repeats.
